// File: rtl/laser_cannon.sv
// Player laser: launches one shot from the ship's gun on a fire edge, walks it down the
// screen once per frame tick, retires it on hit or at the playfield edge, and paints its pixels.
module laser_cannon #(
   parameter int          SCREEN_HEIGHT  = 480,
   parameter int          V_OFFSET       = 10,
   parameter int          SHIP_HEIGHT    = 30,
   parameter int          LASER_WIDTH    = 4,
   parameter int          LASER_HEIGHT   = 12,
   parameter int          LASER_STEP     = 8,
   parameter int          COOLDOWN_TICKS = 4,
   parameter logic [2:0]  LASER          = 3'd6,
   parameter logic [2:0]  NONE           = 3'd7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       fire,
   input  logic       hit,
   input  logic [9:0] gunPosition,
   input  logic [9:0] hPos,
   input  logic [9:0] vPos,
   output logic [9:0] laserX,
   output logic [9:0] laserY,
   output logic       laserActive,
   output logic [2:0] color
);

   localparam int CW   = $clog2(COOLDOWN_TICKS + 1);
   localparam int HALF = LASER_WIDTH / 2;

   typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

   state_t        state, state_next;
   logic          fire_prev;
   logic          pending;
   logic [CW-1:0] cnt;
   logic          rise, launch, advance, retire, cnt_dec, at_edge;
   logic [10:0]   x_lo, x_hi, y_hi;
   logic          in_shot;

   assign rise    = fire & ~fire_prev;
   assign at_edge = ({1'b0, laserY} + 11'(LASER_HEIGHT + LASER_STEP))
                    >= 11'(SCREEN_HEIGHT - V_OFFSET);

   always_comb begin
      state_next = state;
      launch     = 1'b0;
      advance    = 1'b0;
      retire     = 1'b0;
      cnt_dec    = 1'b0;
      case (state)
         IDLE: begin
            // a press arriving on the tick itself still launches
            if (enable && (pending || rise)) begin
               launch     = 1'b1;
               state_next = FLYING;
            end
         end
         FLYING: begin
            if (hit) begin
               retire     = 1'b1;
               state_next = COOLDOWN;
            end else if (enable) begin
               if (at_edge) begin
                  retire     = 1'b1;
                  state_next = COOLDOWN;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         COOLDOWN: begin
            if (enable) begin
               if (cnt == CW'(1)) state_next = IDLE;
               else               cnt_dec    = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fire_prev   <= 1'b0;
         pending     <= 1'b0;
         cnt         <= '0;
         laserX      <= '0;
         laserY      <= '0;
         laserActive <= 1'b0;
      end else begin
         fire_prev   <= fire;
         laserActive <= (state_next == FLYING);
         if (launch)                       pending <= 1'b0;
         else if (state == IDLE && rise)   pending <= 1'b1;
         if (launch) begin
            laserX <= gunPosition;
            laserY <= 10'(V_OFFSET + SHIP_HEIGHT);
         end else if (advance) begin
            laserY <= laserY + 10'(LASER_STEP);
         end
         if (retire)       cnt <= CW'(COOLDOWN_TICKS);
         else if (cnt_dec) cnt <= cnt - CW'(1);
      end
   end

   // left edge clamps at column 0 when the shot hugs the screen edge
   assign x_lo    = ({1'b0, laserX} >= 11'(HALF)) ? ({1'b0, laserX} - 11'(HALF)) : '0;
   assign x_hi    = {1'b0, laserX} + 11'(HALF);
   assign y_hi    = {1'b0, laserY} + 11'(LASER_HEIGHT);
   assign in_shot = (state == FLYING)
                    && ({1'b0, hPos} >= x_lo) && ({1'b0, hPos} < x_hi)
                    && (vPos >= laserY) && ({1'b0, vPos} < y_hi);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) color <= NONE;
      else       color <= in_shot ? LASER : NONE;
   end

endmodule

// File: tb/tb_laser_cannon.sv
// Directed bench for laser_cannon: reset, launch, flight/expiry, hit priority, pixels, fire edge rules.
module tb_laser_cannon;

   logic       clk, reset, enable, fire, hit;
   logic [9:0] gunPosition, hPos, vPos;
   logic [9:0] laserX, laserY;
   logic       laserActive;
   logic [2:0] color;

   int checks   = 0;
   int failures = 0;

   localparam logic [2:0] C_LASER = 3'd6;
   localparam logic [2:0] C_NONE  = 3'd7;

   laser_cannon dut (
      .clk(clk), .reset(reset), .enable(enable), .fire(fire), .hit(hit),
      .gunPosition(gunPosition), .hPos(hPos), .vPos(vPos),
      .laserX(laserX), .laserY(laserY), .laserActive(laserActive), .color(color)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      enable = 1'b1;
      cyc();
      enable = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; fire = 1'b0; hit = 1'b0; enable = 1'b0;
      cyc();
      reset = 1'b0;
      cyc();
   endtask

   task automatic launch_at(input logic [9:0] pos);
      gunPosition = pos;
      fire = 1'b1;
      cyc();
      tick();
      fire = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      cyc();
      checks++; if (laserX !== 10'd0) begin failures++; $display("FAIL reset_x got=%0d want=0", laserX); end
      checks++; if (laserY !== 10'd0) begin failures++; $display("FAIL reset_y got=%0d want=0", laserY); end
      checks++; if (laserActive !== 1'b0) begin failures++; $display("FAIL reset_active got=%b want=0", laserActive); end
      checks++; if (color !== C_NONE) begin failures++; $display("FAIL reset_color got=%0d want=7", color); end
      reset = 1'b0;
      cyc();
      launch_at(10'd320);
      tick();
      checks++; if (laserY !== 10'd48) begin failures++; $display("FAIL pre_reset_y got=%0d want=48", laserY); end
      reset = 1'b1;
      #1;
      checks++; if (laserActive !== 1'b0) begin failures++; $display("FAIL async_reset_active got=%b want=0", laserActive); end
      checks++; if (laserY !== 10'd0) begin failures++; $display("FAIL async_reset_y got=%0d want=0", laserY); end
      @(posedge clk); #1;
      checks++; if (color !== C_NONE) begin failures++; $display("FAIL midflight_reset_color got=%0d want=7", color); end
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_launch();
      gunPosition = 10'd320;
      fire = 1'b1;
      cyc();
      checks++; if (laserActive !== 1'b0) begin failures++; $display("FAIL prelaunch_active got=%b want=0", laserActive); end
      tick();
      fire = 1'b0;
      checks++; if (laserX !== 10'd320) begin failures++; $display("FAIL launch_x got=%0d want=320", laserX); end
      checks++; if (laserY !== 10'd40) begin failures++; $display("FAIL launch_y got=%0d want=40", laserY); end
      checks++; if (laserActive !== 1'b1) begin failures++; $display("FAIL launch_active got=%b want=1", laserActive); end
   endtask

   task automatic test_pixels();
      logic [9:0] hp [0:5];
      logic [9:0] vp [0:5];
      logic [2:0] ex [0:5];
      hp = '{10'd318, 10'd321, 10'd322, 10'd317, 10'd318, 10'd320};
      vp = '{10'd45,  10'd51,  10'd45,  10'd45,  10'd52,  10'd40};
      ex = '{C_LASER, C_LASER, C_NONE,  C_NONE,  C_NONE,  C_LASER};
      do_reset();
      hPos = 10'd318; vPos = 10'd45;
      cyc();
      checks++; if (color !== C_NONE) begin failures++; $display("FAIL idle_pixel got=%0d want=7", color); end
      launch_at(10'd320);
      for (int i = 0; i < 6; i++) begin
         hPos = hp[i]; vPos = vp[i];
         cyc();
         checks++;
         if (color !== ex[i]) begin
            failures++;
            $display("FAIL pixel_%0d_%0d got=%0d want=%0d", hp[i], vp[i], color, ex[i]);
         end
      end
      gunPosition = 10'd340;
      tick();
      checks++; if (laserX !== 10'd320) begin failures++; $display("FAIL frozen_x got=%0d want=320", laserX); end
      checks++; if (laserY !== 10'd48) begin failures++; $display("FAIL step_y got=%0d want=48", laserY); end
      // shot centred at x=1: left edge clamps to column 0, so columns 0..2 are lit
      do_reset();
      launch_at(10'd1);
      hp = '{10'd0, 10'd2, 10'd3, 10'd1, 10'd1, 10'd1023};
      vp = '{10'd45, 10'd45, 10'd45, 10'd39, 10'd51, 10'd45};
      ex = '{C_LASER, C_LASER, C_NONE, C_NONE, C_LASER, C_NONE};
      for (int i = 0; i < 6; i++) begin
         hPos = hp[i]; vPos = vp[i];
         cyc();
         checks++;
         if (color !== ex[i]) begin
            failures++;
            $display("FAIL clamp_pixel_%0d_%0d got=%0d want=%0d", hp[i], vp[i], color, ex[i]);
         end
      end
   endtask

   task automatic test_expiry();
      int y;
      do_reset();
      launch_at(10'd320);
      for (int k = 1; k <= 52; k++) begin
         tick();
         y = 40 + 8 * k;
         checks++;
         if (laserY !== 10'(y) || laserActive !== 1'b1) begin
            failures++;
            $display("FAIL flight_tick_%0d y=%0d active=%b want y=%0d active=1", k, laserY, laserActive, y);
         end
      end
      tick();
      checks++; if (laserY !== 10'd456) begin failures++; $display("FAIL expire_y got=%0d want=456", laserY); end
      checks++; if (laserActive !== 1'b0) begin failures++; $display("FAIL expire_active got=%b want=0", laserActive); end
      tick();
      tick();
      fire = 1'b1; cyc(); fire = 1'b0; cyc();
      tick();
      tick();
      checks++; if (laserActive !== 1'b0) begin failures++; $display("FAIL cooldown_end_active got=%b want=0", laserActive); end
      tick();
      checks++; if (laserActive !== 1'b0) begin failures++; $display("FAIL dropped_fire_active got=%b want=0", laserActive); end
      gunPosition = 10'd77;
      fire = 1'b1;
      tick();
      fire = 1'b0;
      checks++; if (laserActive !== 1'b1) begin failures++; $display("FAIL relaunch_active got=%b want=1", laserActive); end
      checks++; if (laserX !== 10'd77) begin failures++; $display("FAIL relaunch_x got=%0d want=77", laserX); end
      checks++; if (laserY !== 10'd40) begin failures++; $display("FAIL relaunch_y got=%0d want=40", laserY); end
   endtask

   task automatic test_hit_priority();
      do_reset();
      launch_at(10'd200);
      for (int k = 0; k < 7; k++) tick();
      checks++; if (laserY !== 10'd96) begin failures++; $display("FAIL prehit_y got=%0d want=96", laserY); end
      hit = 1'b1; enable = 1'b1;
      cyc();
      hit = 1'b0; enable = 1'b0;
      checks++; if (laserY !== 10'd96) begin failures++; $display("FAIL hit_y got=%0d want=96", laserY); end
      checks++; if (laserActive !== 1'b0) begin failures++; $display("FAIL hit_active got=%b want=0", laserActive); end
      tick();
      tick();
      checks++; if (laserY !== 10'd96) begin failures++; $display("FAIL post_hit_y got=%0d want=96", laserY); end
      tick();
      fire = 1'b1;
      tick();
      checks++; if (laserActive !== 1'b0) begin failures++; $display("FAIL last_cooldown_tick_active got=%b want=0", laserActive); end
      tick();
      checks++; if (laserActive !== 1'b0) begin failures++; $display("FAIL cooldown_edge_dropped got=%b want=0", laserActive); end
      fire = 1'b0;
      cyc();
      fire = 1'b1;
      tick();
      fire = 1'b0;
      checks++; if (laserActive !== 1'b1) begin failures++; $display("FAIL same_cycle_launch got=%b want=1", laserActive); end
      checks++; if (laserY !== 10'd40) begin failures++; $display("FAIL same_cycle_y got=%0d want=40", laserY); end
   endtask

   task automatic test_no_autorepeat();
      do_reset();
      gunPosition = 10'd100;
      fire = 1'b1;
      tick();
      checks++; if (laserActive !== 1'b1) begin failures++; $display("FAIL hold_launch_active got=%b want=1", laserActive); end
      checks++; if (laserX !== 10'd100) begin failures++; $display("FAIL hold_launch_x got=%0d want=100", laserX); end
      hit = 1'b1; cyc(); hit = 1'b0;
      checks++; if (laserActive !== 1'b0) begin failures++; $display("FAIL hold_hit_active got=%b want=0", laserActive); end
      for (int k = 0; k < 6; k++) tick();
      checks++; if (laserActive !== 1'b0) begin failures++; $display("FAIL held_fire_repeat got=%b want=0", laserActive); end
      fire = 1'b0; cyc();
      fire = 1'b1; cyc();
      checks++; if (laserActive !== 1'b0) begin failures++; $display("FAIL pending_no_tick got=%b want=0", laserActive); end
      tick();
      fire = 1'b0;
      checks++; if (laserActive !== 1'b1) begin failures++; $display("FAIL repress_launch got=%b want=1", laserActive); end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; fire = 1'b0; hit = 1'b0;
      gunPosition = '0; hPos = '0; vPos = '0;
      test_reset();
      test_launch();
      test_pixels();
      test_expiry();
      test_hit_priority();
      test_no_autorepeat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
